// File: rtl/ubb_nco_phase_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ubb_nco_phase_gen
// Purpose  : NCO phase generator for the UBB receive chain. A phase
//            accumulator advances by a programmable frequency word on every
//            accepted output beat, and an offset is added to form the output
//            phase. Frequency and offset are loaded through an AXI-Stream
//            config channel. The output stream is framed every FRAME_LEN
//            beats with tlast.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   aclk                  in   core clock
//   aresetn               in   asynchronous assert, active-low reset
//   s_axis_config_tdata   in   config word (PHASE_WIDTH bits)
//   s_axis_config_tvalid  in   config word valid
//   s_axis_config_tready  out  config ready (low in reset, high afterwards)
//   s_axis_config_tlast   in   last word of config packet
//   m_axis_nco_tdata      out  phase sample (PHASE_WIDTH bits)
//   m_axis_nco_tuser      out  [0] accumulator wrapped, [1] first after apply
//   m_axis_nco_tvalid     out  sample valid
//   m_axis_nco_tready     in   downstream ready
//   m_axis_nco_tlast      out  last sample of frame
// ----------------------------------------------------------------------------
// Config packets
//   {FREQ + tlast}            frequency-only update, phase stays continuous
//   {FREQ, OFFSET + tlast}    full apply: accumulator and frame counter clear
//   {FREQ, OFFSET, ... + tlast} full apply on the second word, rest dropped
// ----------------------------------------------------------------------------
// Compile option
//   NCO_PHASE_DITHER_EN : when defined, a 16-bit Fibonacci LFSR
//   (taps 16,14,13,11, seed 0xACE1) adds its low DITHER_BITS to the output
//   phase. The accumulator itself is never dithered and the first sample
//   after a full apply is undithered.
// ============================================================================
module ubb_nco_phase_gen #(
  parameter int PHASE_WIDTH = 32,
  parameter int FRAME_LEN   = 1024,
  parameter int DITHER_BITS = 4
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [PHASE_WIDTH-1:0] s_axis_config_tdata,
  input  logic                   s_axis_config_tvalid,
  output logic                   s_axis_config_tready,
  input  logic                   s_axis_config_tlast,
  output logic [PHASE_WIDTH-1:0] m_axis_nco_tdata,
  output logic [1:0]             m_axis_nco_tuser,
  output logic                   m_axis_nco_tvalid,
  input  logic                   m_axis_nco_tready,
  output logic                   m_axis_nco_tlast
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int             CNT_W         = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(FRAME_LEN - 1);
  localparam logic           FIRST_IS_LAST = (FRAME_LEN == 1);

  localparam logic [1:0] CFG_W0    = 2'd0;
  localparam logic [1:0] CFG_W1    = 2'd1;
  localparam logic [1:0] CFG_DRAIN = 2'd2;

  // Elaboration-time parameter range checks.
  generate
    if ((FRAME_LEN < 2) || (FRAME_LEN > 65536)) begin : g_bad_frame_len
      $error("ubb_nco_phase_gen: FRAME_LEN must be 2..65536");
    end
    if ((DITHER_BITS < 1) || (DITHER_BITS > 16)) begin : g_bad_dither_bits
      $error("ubb_nco_phase_gen: DITHER_BITS must be 1..16");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic                   cfg_ready_q,    cfg_ready_d;
  logic [1:0]             state_q,        state_d;
  logic [PHASE_WIDTH-1:0] pending_freq_q, pending_freq_d;
  logic [PHASE_WIDTH-1:0] freq_q,         freq_d;
  logic [PHASE_WIDTH-1:0] offset_q,       offset_d;
  logic [PHASE_WIDTH-1:0] acc_q,          acc_d;
  logic [CNT_W-1:0]       cnt_q,          cnt_d;
  logic                   nco_valid_q,    nco_valid_d;
  logic [PHASE_WIDTH-1:0] nco_data_q,     nco_data_d;
  logic [1:0]             nco_user_q,     nco_user_d;
  logic                   nco_last_q,     nco_last_d;

  // --------------------------------------------------------------------------
  // Combinational wires
  // --------------------------------------------------------------------------
  logic                   w_cfg_hs;
  logic                   w_out_hs;
  logic                   w_latch_pending;
  logic                   w_apply_freq;
  logic                   w_apply_full;
  logic                   w_carry;
  logic [PHASE_WIDTH-1:0] w_acc_step;
  logic [CNT_W-1:0]       w_cnt_step;
  logic [PHASE_WIDTH-1:0] w_dither;

  assign w_cfg_hs = s_axis_config_tvalid & cfg_ready_q;
  assign w_out_hs = nco_valid_q & m_axis_nco_tready;

  // Accumulator step with its carry; the carry is the wrap flag in tuser[0].
  assign {w_carry, w_acc_step} = {1'b0, acc_q} + {1'b0, freq_q};

  assign w_cnt_step = (cnt_q == CNT_LAST) ? '0 : (cnt_q + CNT_W'(1));

  // --------------------------------------------------------------------------
  // Config FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= CFG_W0;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Config FSM: next-state logic (advances only on config handshake)
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (w_cfg_hs) begin
      case (state_q)
        CFG_W0: begin
          if (!s_axis_config_tlast) begin
            state_d = CFG_W1;
          end
        end
        CFG_W1: begin
          state_d = s_axis_config_tlast ? CFG_W0 : CFG_DRAIN;
        end
        CFG_DRAIN: begin
          if (s_axis_config_tlast) begin
            state_d = CFG_W0;
          end
        end
        default: begin
          state_d = CFG_W0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Config FSM: output decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_latch_pending = 1'b0;
    w_apply_freq    = 1'b0;
    w_apply_full    = 1'b0;
    if (w_cfg_hs) begin
      case (state_q)
        CFG_W0: begin
          w_latch_pending = ~s_axis_config_tlast;
          w_apply_freq    = s_axis_config_tlast;
        end
        CFG_W1: begin
          // Second word always applies; a missing tlast only sends the FSM
          // to drain the remainder of the packet.
          w_apply_full = 1'b1;
        end
        default: begin
          w_latch_pending = 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Optional output dither
  // --------------------------------------------------------------------------
`ifdef NCO_PHASE_DITHER_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] w_lfsr_step;
  logic        w_lfsr_fb;

  // Right-shifting Fibonacci form of x^16 + x^14 + x^13 + x^11 + 1.
  assign w_lfsr_fb   = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
  assign w_lfsr_step = {w_lfsr_fb, lfsr_q[15:1]};

  // The sample produced by a step uses the freshly stepped LFSR value.
  assign w_dither = PHASE_WIDTH'(w_lfsr_step[DITHER_BITS-1:0]);

  always_comb begin
    lfsr_d = lfsr_q;
    if (w_out_hs) begin
      lfsr_d = w_lfsr_step;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign w_dither = '0;
`endif

  // --------------------------------------------------------------------------
  // Datapath next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    cfg_ready_d    = 1'b1;
    pending_freq_d = pending_freq_q;
    freq_d         = freq_q;
    offset_d       = offset_q;
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    nco_valid_d    = nco_valid_q;
    nco_data_d     = nco_data_q;
    nco_user_d     = nco_user_q;
    nco_last_d     = nco_last_q;

    if (w_latch_pending) begin
      pending_freq_d = s_axis_config_tdata;
    end

    if (w_apply_full) begin
      // A full apply overrides any output step on the same edge: the sample
      // being accepted is consumed and the post-apply sample replaces it.
      freq_d      = pending_freq_q;
      offset_d    = s_axis_config_tdata;
      acc_d       = '0;
      cnt_d       = '0;
      nco_valid_d = 1'b1;
      nco_data_d  = s_axis_config_tdata;
      nco_user_d  = 2'b10;
      nco_last_d  = FIRST_IS_LAST;
    end else if (w_out_hs) begin
      acc_d      = w_acc_step;
      cnt_d      = w_cnt_step;
      nco_data_d = w_acc_step + offset_q + w_dither;
      nco_user_d = {1'b0, w_carry};
      nco_last_d = (w_cnt_step == CNT_LAST);
    end

    // Frequency-only update: a concurrent step above already used the old
    // frequency, so the new one takes effect from the next step.
    if (w_apply_freq) begin
      freq_d = s_axis_config_tdata;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cfg_ready_q    <= 1'b0;
      pending_freq_q <= '0;
      freq_q         <= '0;
      offset_q       <= '0;
      acc_q          <= '0;
      cnt_q          <= '0;
      nco_valid_q    <= 1'b0;
      nco_data_q     <= '0;
      nco_user_q     <= 2'b00;
      nco_last_q     <= 1'b0;
    end else begin
      cfg_ready_q    <= cfg_ready_d;
      pending_freq_q <= pending_freq_d;
      freq_q         <= freq_d;
      offset_q       <= offset_d;
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      nco_valid_q    <= nco_valid_d;
      nco_data_q     <= nco_data_d;
      nco_user_q     <= nco_user_d;
      nco_last_q     <= nco_last_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign s_axis_config_tready = cfg_ready_q;
  assign m_axis_nco_tvalid    = nco_valid_q;
  assign m_axis_nco_tdata     = nco_data_q;
  assign m_axis_nco_tuser     = nco_user_q;
  assign m_axis_nco_tlast     = nco_last_q;

endmodule

`default_nettype wire

// File: tb/tb_ubb_nco_phase_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ubb_nco_phase_gen
// Purpose  : Self-checking bench for ubb_nco_phase_gen. A packet-level
//            reference model (config word queue, modular phase arithmetic,
//            sample index) predicts every output beat.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ubb_nco_phase_gen;

  localparam int PW = 32;
  localparam int FL = 4;
  localparam int DB = 4;

  logic          aclk    = 1'b0;
  logic          aresetn = 1'b0;
  logic [PW-1:0] s_axis_config_tdata  = '0;
  logic          s_axis_config_tvalid = 1'b0;
  logic          s_axis_config_tready;
  logic          s_axis_config_tlast  = 1'b0;
  logic [PW-1:0] m_axis_nco_tdata;
  logic [1:0]    m_axis_nco_tuser;
  logic          m_axis_nco_tvalid;
  logic          m_axis_nco_tready    = 1'b0;
  logic          m_axis_nco_tlast;

  always #5 aclk = ~aclk;

  ubb_nco_phase_gen #(
    .PHASE_WIDTH (PW),
    .FRAME_LEN   (FL),
    .DITHER_BITS (DB)
  ) dut (
    .aclk                 (aclk),
    .aresetn              (aresetn),
    .s_axis_config_tdata  (s_axis_config_tdata),
    .s_axis_config_tvalid (s_axis_config_tvalid),
    .s_axis_config_tready (s_axis_config_tready),
    .s_axis_config_tlast  (s_axis_config_tlast),
    .m_axis_nco_tdata     (m_axis_nco_tdata),
    .m_axis_nco_tuser     (m_axis_nco_tuser),
    .m_axis_nco_tvalid    (m_axis_nco_tvalid),
    .m_axis_nco_tready    (m_axis_nco_tready),
    .m_axis_nco_tlast     (m_axis_nco_tlast)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0] m_freq, m_off, m_acc, m_data;
  logic [1:0]  m_user;
  logic        m_last, m_valid, m_cfg_rdy;
  int          m_idx;
  logic [15:0] m_lfsr;
  logic [31:0] pkt[$];

  wire [36:0] dut_vec = {s_axis_config_tready, m_axis_nco_tvalid, m_axis_nco_tdata,
                         m_axis_nco_tuser, m_axis_nco_tlast};

  function automatic logic [36:0] exp_vec();
    return {m_cfg_rdy, m_valid, m_data, m_user, m_last};
  endfunction

  task automatic model_reset();
    m_freq = 0; m_off = 0; m_acc = 0; m_data = 0; m_user = 0;
    m_last = 0; m_valid = 0; m_cfg_rdy = 0; m_idx = 0;
    m_lfsr = 16'hACE1;
    pkt.delete();
  endtask

  // One clock cycle: drive inputs, let the edge happen, advance the model.
  task automatic tick(input logic cv, input logic [31:0] cd, input logic cl, input logic rd);
    logic        chs, ohs, full, fonly, fb;
    logic [31:0] nf, no, fval, dith;
    longint      s;
    s_axis_config_tvalid = cv;
    s_axis_config_tdata  = cd;
    s_axis_config_tlast  = cl;
    m_axis_nco_tready    = rd;
    chs = cv & m_cfg_rdy;
    ohs = m_valid & rd;
    @(posedge aclk);
    full = 0; fonly = 0; nf = 0; no = 0; fval = 0;
    if (chs) begin
      pkt.push_back(cd);
      if (pkt.size() == 2) begin
        full = 1; nf = pkt[0]; no = pkt[1];
      end else if (pkt.size() == 1 && cl) begin
        fonly = 1; fval = cd;
      end
      if (cl) pkt.delete();
    end
    if (ohs) begin
      fb = m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5];
      m_lfsr = {fb, m_lfsr[15:1]};
    end
`ifdef NCO_PHASE_DITHER_EN
    dith = 32'(m_lfsr % (16'd1 << DB));
`else
    dith = 0;
`endif
    if (full) begin
      m_freq = nf; m_off = no; m_acc = 0; m_idx = 0;
      m_data = no; m_user = 2'b10; m_last = (FL == 1); m_valid = 1;
    end else if (ohs) begin
      s      = longint'(m_acc) + longint'(m_freq);
      m_acc  = 32'(s);
      m_idx  = (m_idx + 1) % FL;
      m_data = m_acc + m_off + dith;
      m_user = {1'b0, (s >= 64'h1_0000_0000)};
      m_last = (m_idx == FL - 1);
    end
    if (fonly) m_freq = fval;
    m_cfg_rdy = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    aresetn = 0;
    model_reset();
    repeat (2) @(posedge aclk);
    #1;
    checks++;
    if (dut_vec !== 37'h0) begin
      errors++; $display("FAIL reset_state: got %h expected %h", dut_vec, 37'h0);
    end
    aresetn = 1;
    #1;
    checks++;
    if (s_axis_config_tready !== 1'b0) begin
      errors++; $display("FAIL ready_before_edge: got %b expected 0", s_axis_config_tready);
    end
    tick(0, 0, 0, 0);
    checks++;
    if (s_axis_config_tready !== 1'b1 || m_axis_nco_tvalid !== 1'b0) begin
      errors++; $display("FAIL ready_after_edge: got rdy=%b vld=%b expected rdy=1 vld=0",
                         s_axis_config_tready, m_axis_nco_tvalid);
    end
  endtask

  task automatic test_basic();
    logic [31:0] ed [5] = '{32'h0, 32'h40000000, 32'h80000000, 32'hC0000000, 32'h0};
    logic [1:0]  eu [5] = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b01};
    tick(1, 32'h40000000, 0, 1);
    tick(1, 32'h0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick(0, 0, 0, 1);
`ifndef NCO_PHASE_DITHER_EN
      checks++;
      if (m_axis_nco_tdata !== ed[i] || m_axis_nco_tuser !== eu[i] || m_axis_nco_tvalid !== 1'b1) begin
        errors++; $display("FAIL basic_seq[%0d]: got data=%h user=%b expected data=%h user=%b",
                           i, m_axis_nco_tdata, m_axis_nco_tuser, ed[i], eu[i]);
      end
`endif
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL basic_model[%0d]: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] ea [4] = '{32'h100, 32'h10000100, 32'h20000100, 32'h30000100};
    logic        el [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] pd;
    logic [1:0]  pu;
    logic        pl;
    int          k;
    tick(1, 32'h10000000, 0, 0);
    tick(1, 32'h00000100, 1, 0);
    k = 0;
    for (int i = 0; i < 8; i++) begin
      pd = m_axis_nco_tdata; pu = m_axis_nco_tuser; pl = m_axis_nco_tlast;
      tick(0, 0, 0, (i % 2) == 0);
      if ((i % 2) == 0) begin
`ifndef NCO_PHASE_DITHER_EN
        checks++;
        if (pd !== ea[k] || pl !== el[k]) begin
          errors++; $display("FAIL bp_accepted[%0d]: got data=%h last=%b expected data=%h last=%b",
                             k, pd, pl, ea[k], el[k]);
        end
`endif
        k++;
      end else begin
        checks++;
        if (m_axis_nco_tdata !== pd || m_axis_nco_tuser !== pu || m_axis_nco_tlast !== pl) begin
          errors++; $display("FAIL bp_hold[%0d]: got %h/%b/%b expected %h/%b/%b", i,
                             m_axis_nco_tdata, m_axis_nco_tuser, m_axis_nco_tlast, pd, pu, pl);
        end
      end
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL bp_model[%0d]: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_freq_only();
    logic [31:0] ed [3] = '{32'h40000000, 32'h60000000, 32'h80000000};
    tick(1, 32'h10000000, 0, 0);
    tick(1, 32'h0, 1, 0);
    repeat (3) tick(0, 0, 0, 1);
`ifndef NCO_PHASE_DITHER_EN
    checks++;
    if (m_axis_nco_tdata !== 32'h30000000 || m_axis_nco_tlast !== 1'b1) begin
      errors++; $display("FAIL fo_start: got data=%h last=%b expected data=30000000 last=1",
                         m_axis_nco_tdata, m_axis_nco_tlast);
    end
`endif
    for (int i = 0; i < 3; i++) begin
      if (i == 0) tick(1, 32'h20000000, 1, 1);
      else        tick(0, 0, 0, 1);
`ifndef NCO_PHASE_DITHER_EN
      checks++;
      if (m_axis_nco_tdata !== ed[i] || m_axis_nco_tuser[1] !== 1'b0) begin
        errors++; $display("FAIL fo_seq[%0d]: got data=%h user=%b expected data=%h user[1]=0",
                           i, m_axis_nco_tdata, m_axis_nco_tuser, ed[i]);
      end
`endif
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL fo_model[%0d]: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_three_word();
    logic [31:0] a, b, c, a2, b2;
    a = $urandom; b = $urandom; c = $urandom; a2 = $urandom; b2 = $urandom;
    tick(1, a, 0, 0);
    tick(1, b, 0, 0);
    checks++;
    if (m_axis_nco_tdata !== b || m_axis_nco_tuser !== 2'b10 || m_axis_nco_tvalid !== 1'b1) begin
      errors++; $display("FAIL tw_apply: got data=%h user=%b expected data=%h user=10",
                         m_axis_nco_tdata, m_axis_nco_tuser, b);
    end
    tick(1, c, 1, 0);
    tick(0, 0, 0, 1);
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++; $display("FAIL tw_step: got %h expected %h", dut_vec, exp_vec());
    end
    tick(1, a2, 0, 0);
    tick(1, b2, 1, 0);
    checks++;
    if (m_axis_nco_tdata !== b2 || m_axis_nco_tuser !== 2'b10) begin
      errors++; $display("FAIL tw_reparse: got data=%h user=%b expected data=%h user=10",
                         m_axis_nco_tdata, m_axis_nco_tuser, b2);
    end
    tick(0, 0, 0, 1);
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++; $display("FAIL tw_step2: got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_collision();
    logic [31:0] f, o;
    f = $urandom; o = $urandom;
    tick(1, f, 0, 1);
    tick(1, o, 1, 1);
    checks++;
    if (m_axis_nco_tdata !== o || m_axis_nco_tuser !== 2'b10) begin
      errors++; $display("FAIL coll_apply: got data=%h user=%b expected data=%h user=10",
                         m_axis_nco_tdata, m_axis_nco_tuser, o);
    end
    repeat (3) begin
      tick(0, 0, 0, 1);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL coll_model: got %h expected %h", dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_freq_zero();
    logic [31:0] o;
    o = $urandom;
    tick(1, 32'h0, 0, 0);
    tick(1, o, 1, 0);
    for (int i = 0; i < 6; i++) begin
      tick(0, 0, 0, 1);
`ifndef NCO_PHASE_DITHER_EN
      checks++;
      if (m_axis_nco_tdata !== o) begin
        errors++; $display("FAIL fz_const[%0d]: got %h expected %h", i, m_axis_nco_tdata, o);
      end
`endif
      checks++;
      if (m_axis_nco_tuser[0] !== 1'b0 || dut_vec !== exp_vec()) begin
        errors++; $display("FAIL fz_model[%0d]: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    tick(1, 32'h01000000, 0, 1);
    tick(1, 32'h5, 1, 1);
    tick(1, 32'h7777, 0, 1);      // partial packet, lost by the reset below
    #2;
    aresetn = 0;
    model_reset();
    #1;
    checks++;
    if (m_axis_nco_tvalid !== 1'b0 || s_axis_config_tready !== 1'b0 || dut_vec !== 37'h0) begin
      errors++; $display("FAIL rst_mid_async: got %h expected %h", dut_vec, 37'h0);
    end
    @(posedge aclk);
    #1;
    aresetn = 1;
    tick(0, 0, 0, 1);
    tick(1, 32'h3, 1, 1);
    checks++;
    if (m_axis_nco_tvalid !== 1'b0 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL rst_mid_silent1: got %h expected %h", dut_vec, exp_vec());
    end
    tick(1, 32'h00100000, 0, 1);
    checks++;
    if (m_axis_nco_tvalid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_silent2: got vld=%b expected 0", m_axis_nco_tvalid);
    end
    tick(1, 32'h42, 1, 1);
    checks++;
    if (m_axis_nco_tvalid !== 1'b1 || m_axis_nco_tdata !== 32'h42 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL rst_mid_reapply: got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_random();
    logic        cv, cl, rd;
    logic [31:0] cd;
    for (int i = 0; i < 400; i++) begin
      cv = ($urandom_range(0, 3) == 0);
      cl = $urandom_range(0, 1) == 1;
      cd = $urandom;
      rd = ($urandom_range(0, 2) != 0);
      tick(cv, cd, cl, rd);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL rand[%0d]: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
    // Close any open packet so later traffic parses from a known point.
    tick(1, 32'h0, 1, 1);
  endtask

`ifdef NCO_PHASE_DITHER_EN
  task automatic test_dither();
    tick(1, 32'h0, 0, 0);
    tick(1, 32'h1000, 1, 0);
    checks++;
    if (m_axis_nco_tdata !== 32'h1000) begin
      errors++; $display("FAIL dith_first: got %h expected 00001000", m_axis_nco_tdata);
    end
    for (int i = 0; i < 20; i++) begin
      tick(0, 0, 0, $urandom_range(0, 1) == 1);
      checks++;
      if (m_axis_nco_tdata < 32'h1000 || m_axis_nco_tdata > 32'h100F || dut_vec !== exp_vec()) begin
        errors++; $display("FAIL dith[%0d]: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected run completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_freq_only();
    test_three_word();
    test_collision();
    test_freq_zero();
    test_reset_mid();
    test_random();
`ifdef NCO_PHASE_DITHER_EN
    test_dither();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
